alu_10b: RTL and testbench



---
 rtl/alu_10b_pkg.sv | 15 +
 rtl/alu_10b_comb.sv | 36 +++
 rtl/alu_10b.sv | 56 +++++
 tb/tb_alu_10b.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_10b_pkg.sv
// Shared opcode encodings and default operand width for the alu_10b ALU.
package alu_10b_pkg;

  localparam int WIDTH_DEF = 10;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_10b_comb.sv
// Combinational opcode decode and datapath for alu_10b; all operations are
// evaluated at 2*WIDTH bits on zero-extended operands.
module alu_10b_comb
  import alu_10b_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         sel,
  output logic [2*WIDTH-1:0] res
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;

  assign a_ext = {{WIDTH{1'b0}}, a};
  assign b_ext = {{WIDTH{1'b0}}, b};

  // Shift opcodes use only a_ext, so an undriven b cannot leak into them.
  always_comb begin
    res = '0;
    case (sel)
      OP_ADD:  res = a_ext + b_ext;
      OP_SUB:  res = a_ext - b_ext;
      OP_MUL:  res = a_ext * b_ext;
      OP_XOR:  res = a_ext ^ b_ext;
      OP_AND:  res = a_ext & b_ext;
      OP_OR:   res = a_ext | b_ext;
      OP_SHL:  res = a_ext << 1;
      OP_SHR:  res = a_ext >> 1;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_10b.sv
// Registered 8-operation ALU, one cycle latency from in_valid to out_valid.
// Define ALU_FLAGS_EN to add registered zero_flag / neg_flag outputs.
module alu_10b
  import alu_10b_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         sel,
  output logic [2*WIDTH-1:0] y,
`ifdef ALU_FLAGS_EN
  output logic               out_valid,
  output logic               zero_flag,
  output logic               neg_flag
`else
  output logic               out_valid
`endif
);

  logic [2*WIDTH-1:0] res;

  alu_10b_comb #(.WIDTH(WIDTH)) u_comb (
    .a   (a),
    .b   (b),
    .sel (sel),
    .res (res)
  );

  // y holds its last value whenever no new operands are presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) y <= res;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else if (in_valid) begin
      zero_flag <= (res == '0);
      neg_flag  <= res[2*WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_10b.sv
// Self-checking bench for alu_10b: expected results are queued when operands
// are driven and popped when the registered result appears.
module tb_alu_10b;
  import alu_10b_pkg::*;

  localparam int W = 10;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [2:0]      sel;
  logic [2*W-1:0]  y;
  logic            out_valid;
`ifdef ALU_FLAGS_EN
  logic            zero_flag;
  logic            neg_flag;
`endif

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_y = '0;

  typedef struct {
    logic [2:0]     s;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] e;
  } vec_t;

  alu_10b #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .y         (y),
`ifdef ALU_FLAGS_EN
    .out_valid (out_valid),
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag)
`else
    .out_valid (out_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] z);
    longint unsigned p;
    p = longint'(x) * longint'(z);
    return p[2*W-1:0];
  endfunction

  task automatic drive(input logic [2:0] s, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [2*W-1:0] e);
    @(negedge clk);
    in_valid = 1'b1;
    sel      = s;
    a        = aa;
    b        = bb;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (y !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: y=%0d out_valid=%b, expected y=0 out_valid=0", y, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith();
    vec_t v[3] = '{'{OP_ADD, 10'd31, 10'd3, 20'd34},
                   '{OP_SUB, 10'd32, 10'd4, 20'd28},
                   '{OP_MUL, 10'd20, 10'd4, 20'd80}};
    logic [2*W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(v[i].s, v[i].a, v[i].b, v[i].e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || y !== e) begin
        errors++;
        $display("FAIL arith[%0d]: y=%0d out_valid=%b, expected y=%0d out_valid=1", i, y, out_valid, e);
      end
      last_y = e;
    end
  endtask

  task automatic test_logic_shift();
    vec_t v[6] = '{'{OP_AND, 10'd963, 10'd682, 20'd642},
                   '{OP_OR,  10'd588, 10'd403, 20'd991},
                   '{OP_XOR, 10'd963, 10'd682, 20'd361},
                   '{OP_SHL, 10'd60,  10'd777, 20'd120},
                   '{OP_SHR, 10'd960, 10'd555, 20'd480},
                   '{OP_SHR, 10'd1,   10'd1023, 20'd0}};
    logic [2*W-1:0] e;
    for (int i = 0; i < 6; i++) begin
      drive(v[i].s, v[i].a, v[i].b, v[i].e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || y !== e) begin
        errors++;
        $display("FAIL logic_shift[%0d]: y=%0d out_valid=%b, expected y=%0d out_valid=1", i, y, out_valid, e);
      end
      last_y = e;
    end
  endtask

  task automatic test_edges();
    vec_t v[7] = '{'{OP_ADD, 10'd1023, 10'd1023, 20'd2046},
                   '{OP_MUL, 10'd1023, 10'd1023, 20'd1046529},
                   '{OP_SUB, 10'd0,    10'd0,    20'd0},
                   '{OP_SUB, 10'd0,    10'd1,    20'd1048575},
                   '{OP_SHL, 10'd1023, 10'd0,    20'd2046},
                   '{OP_SUB, 10'd1014, 10'd5,    20'd1009},
                   '{OP_MUL, 10'd1018, 10'd3,    20'd3054}};
    logic [2*W-1:0] e;
    for (int i = 0; i < 7; i++) begin
      drive(v[i].s, v[i].a, v[i].b, v[i].e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || y !== e) begin
        errors++;
        $display("FAIL edges[%0d]: y=%0d out_valid=%b, expected y=%0d out_valid=1", i, y, out_valid, e);
      end
      last_y = e;
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      sel = 3'($urandom_range(0, 7));
      a   = W'($urandom_range(0, 1023));
      b   = W'($urandom_range(0, 1023));
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || y !== last_y) begin
        errors++;
        $display("FAIL hold[%0d]: y=%0d out_valid=%b, expected y=%0d out_valid=0", i, y, out_valid, last_y);
      end
    end
  endtask

  task automatic test_reset_override();
    logic [2*W-1:0] e;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    sel = OP_ADD;
    a = 10'd100;
    b = 10'd200;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || y !== '0) begin
      errors++;
      $display("FAIL reset_override: y=%0d out_valid=%b, expected y=0 out_valid=0", y, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    drive(OP_ADD, 10'd1, 10'd2, 20'd3);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || y !== e) begin
      errors++;
      $display("FAIL after_reset: y=%0d out_valid=%b, expected y=%0d out_valid=1", y, out_valid, e);
    end
    last_y = e;
  endtask

  task automatic test_back_to_back_mul();
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] e;
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom_range(0, 1023));
      rb = W'($urandom_range(0, 1023));
      drive(OP_MUL, ra, rb, ref_mul(ra, rb));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || y !== e) begin
        errors++;
        $display("FAIL rand_mul[%0d] %0d*%0d: y=%0d out_valid=%b, expected y=%0d out_valid=1",
                 i, ra, rb, y, out_valid, e);
      end
      last_y = e;
    end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic test_flags();
    vec_t v[3] = '{'{OP_SUB, 10'd5, 10'd5, 20'd0},
                   '{OP_SUB, 10'd0, 10'd1, 20'd1048575},
                   '{OP_ADD, 10'd7, 10'd8, 20'd15}};
    logic [2*W-1:0] e;
    logic ez, en;
    for (int i = 0; i < 3; i++) begin
      drive(v[i].s, v[i].a, v[i].b, v[i].e);
      @(posedge clk); #1;
      e  = exp_q.pop_front();
      ez = (i == 0);
      en = (i == 1);
      checks++;
      if (y !== e || zero_flag !== ez || neg_flag !== en) begin
        errors++;
        $display("FAIL flags[%0d]: y=%0d zero=%b neg=%b, expected y=%0d zero=%b neg=%b",
                 i, y, zero_flag, neg_flag, e, ez, en);
      end
      last_y = e;
    end
    @(negedge clk);
    in_valid = 1'b0;
    sel = OP_SUB;
    a = 10'd0;
    b = 10'd0;
    @(posedge clk); #1;
    checks++;
    if (zero_flag !== 1'b0 || neg_flag !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flags_hold: zero=%b neg=%b out_valid=%b, expected zero=0 neg=0 out_valid=0",
               zero_flag, neg_flag, out_valid);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sel = OP_ADD;
    test_reset();
    test_arith();
    test_logic_shift();
    test_edges();
    test_hold();
    test_reset_override();
    test_back_to_back_mul();
`ifdef ALU_FLAGS_EN
    test_flags();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
